averager_counter: RTL and testbench
===================================

AVERAGER_COUNTER -- requirements
Module: averager_counter

Interface
REQ-001 Parameter FAST_COUNT_WIDTH, default 5: width of the fast (sample-index) counter.
REQ-002 Parameter SLOW_COUNT_WIDTH, default 10: width of the slow (pass/average) counter.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 restart  input  1  request to end the current average and start a new one.
REQ-007 clken  input  1  count enable; when low, all counters and outputs hold.
REQ-008 count_max  input  FAST_COUNT_WIDTH  last fast_count value of a pass; pass length = count_max+1.
REQ-009 fast_count  output  FAST_COUNT_WIDTH  sample index within the pass.
REQ-010 slow_count  output  SLOW_COUNT_WIDTH  number of completed passes since the last restart took effect.
REQ-011 init  output  1  high during the first pass after a restart takes effect (accumulator loads instead of adding).
REQ-012 ready  output  1  one-cycle pulse: n_avg has just been updated.
REQ-013 wen  output  1  accumulator-memory write enable.
REQ-014 n_avg  output  SLOW_COUNT_WIDTH  number of passes in the last finished average.
REQ-015 address  output  FAST_COUNT_WIDTH+2  byte address of the 32-bit word for the current sample.

Function
REQ-016 wrap = clken AND (fast_count >= count_max), evaluated against the live count_max.
REQ-017 When clken is high and wrap is false, fast_count increments by 1 each cycle; when wrap is true, it returns to 0.
REQ-018 restart_pending (internal) shall set on any cycle with restart=1, regardless of clken, and clear on a wrap.
REQ-019 A restart asserted on the wrap cycle itself takes effect at that wrap.
REQ-020 At a wrap with restart_pending or restart high:
- n_avg <= slow_count+1, saturating at all-ones.
- slow_count <= 0.
- init <= 1.
- ready pulses high for exactly that following cycle.
- wen <= 1, latched thereafter.
REQ-021 At a wrap without a restart:
- slow_count <= slow_count+1, saturating at all-ones.
- init <= 0.
- ready stays 0.
REQ-022 wen shall stay 0 from reset until the first restart takes effect, then equal clken.
REQ-023 address = {fast_count, 2'b00}, combinational from fast_count, with zero latency.
REQ-024 With clken low, nothing changes except restart_pending capture, and ready is forced to 0.
REQ-025 count_max = 0: every enabled cycle is a wrap and fast_count stays 0.

Reset
REQ-026 On rst=1, these shall clear asynchronously to 0: fast_count, slow_count, n_avg, init, ready, wen and restart_pending; address is then 0.
REQ-027 rst=1 in mid-pass shall abandon the pass, and operation resumes from fast_count=0 with no average pending.

Structure
REQ-028 Single module with no sub-modules.
REQ-029 No shared package is required, because all widths are derived from the two parameters.

Verification
REQ-030 Hold, at FAST=5, SLOW=10, count_max=15, clken=0 for 10 cycles -> fast_count=0, slow_count=0, wen=0, ready=0.
REQ-031 Free-run, clken=1 -> fast_count runs 0..15 with period 16, slow_count increments once per wrap, wen=0 and init=0 throughout.
REQ-032 Restart in mid-pass:
- Stimulus: a 1-cycle restart 40 cycles after clken rises, at fast_count=8 and slow_count=2.
- Response at the wrap 7 cycles later: n_avg=3, one-cycle ready pulse, slow_count=0, init=1 for 16 cycles, then wen=1 continuously.
REQ-033 Restart on a wrap cycle -> takes effect at that same wrap.
REQ-034 Saturation: SLOW=2, >4 passes, then restart -> slow_count saturates at 3 and n_avg=3.
REQ-035 count_max reduced from 15 to 4 while fast_count=10 -> wrap on the next enabled cycle, then period 5.

Source files
------------

// File: rtl/averager_counter_pkg.sv
// -----------------------------------------------------------------------------
// averager_counter_pkg
// Constants for the averager sample/pass counter.
// The block's widths come entirely from its two parameters. This package only
// fixes how a sample index maps onto a byte address in the accumulator memory.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package averager_counter_pkg;

  // Each accumulator entry is one 32-bit word, which is four bytes.
  // The byte address is therefore the sample index shifted left by two.
  localparam int unsigned WORD_ADDR_SHIFT = 2;

endpackage : averager_counter_pkg

// File: rtl/averager_counter.sv
// -----------------------------------------------------------------------------
// averager_counter
// Sequencing for a running-average engine. A fast counter walks through the
// samples of one pass (0..count_max). A slow counter counts the passes that
// have completed. A restart request ends the current average at the next pass
// boundary (a "wrap"). At that point the averager:
//   - publishes the pass count on n_avg,
//   - pulses ready for one cycle,
//   - raises init for the following pass, so that the accumulator loads
//     instead of adding.
//
// Ports
//   clk        in   clock; all state changes happen on its rising edge
//   rst        in   asynchronous active-high reset
//   restart    in   request to finish the current average and start a new one
//   clken      in   count enable; when it is low, everything holds
//   count_max  in   last sample index of a pass (pass length = count_max+1)
//   fast_count out  sample index within the current pass
//   slow_count out  number of passes completed since the last restart
//   init       out  high during the first pass after a restart
//   ready      out  one-cycle pulse after n_avg has been updated
//   wen        out  accumulator write enable
//   n_avg      out  number of passes in the last finished average
//   address    out  byte address of the current sample's 32-bit word
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module averager_counter
  import averager_counter_pkg::*;
#(
  parameter int FAST_COUNT_WIDTH = 5,
  parameter int SLOW_COUNT_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          restart,
  input  logic                          clken,
  input  logic [FAST_COUNT_WIDTH-1:0]   count_max,
  output logic [FAST_COUNT_WIDTH-1:0]   fast_count,
  output logic [SLOW_COUNT_WIDTH-1:0]   slow_count,
  output logic                          init,
  output logic                          ready,
  output logic                          wen,
  output logic [SLOW_COUNT_WIDTH-1:0]   n_avg,
  output logic [FAST_COUNT_WIDTH+1:0]   address
);

  localparam logic [FAST_COUNT_WIDTH-1:0] FAST_ONE = FAST_COUNT_WIDTH'(1);
  localparam logic [SLOW_COUNT_WIDTH-1:0] SLOW_ONE = SLOW_COUNT_WIDTH'(1);

  logic [FAST_COUNT_WIDTH-1:0] fast_count_q, fast_count_d;
  logic [SLOW_COUNT_WIDTH-1:0] slow_count_q, slow_count_d;
  logic [SLOW_COUNT_WIDTH-1:0] n_avg_q, n_avg_d;
  logic                        init_q, init_d;
  logic                        ready_q, ready_d;
  logic                        armed_q, armed_d;
  logic                        restart_pending_q, restart_pending_d;

  logic                        wrap;
  logic                        restart_now;
  logic [SLOW_COUNT_WIDTH-1:0] slow_count_inc;

  // Use ">=" rather than "==". If count_max is lowered below the current
  // index in mid-pass, the pass ends on the next enabled cycle instead of
  // running all the way around the counter.
  assign wrap        = clken & (fast_count_q >= count_max);

  // A restart on the wrap cycle itself counts, as well as one captured earlier.
  assign restart_now = restart | restart_pending_q;

  // Saturating pass count. It feeds both the next slow_count and n_avg.
  assign slow_count_inc = (slow_count_q == {SLOW_COUNT_WIDTH{1'b1}})
                        ? slow_count_q
                        : slow_count_q + SLOW_ONE;

  always_comb begin
    fast_count_d      = fast_count_q;
    slow_count_d      = slow_count_q;
    n_avg_d           = n_avg_q;
    init_d            = init_q;
    armed_d           = armed_q;
    ready_d           = 1'b0;
    // The restart request is captured even while clken is low. It is only
    // consumed at a wrap, and a wrap always acts on it.
    restart_pending_d = wrap ? 1'b0 : (restart_pending_q | restart);

    if (clken) begin
      if (wrap) begin
        fast_count_d = '0;
        if (restart_now) begin
          n_avg_d      = slow_count_inc;
          slow_count_d = '0;
          init_d       = 1'b1;
          ready_d      = 1'b1;
          armed_d      = 1'b1;
        end else begin
          slow_count_d = slow_count_inc;
          init_d       = 1'b0;
        end
      end else begin
        fast_count_d = fast_count_q + FAST_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fast_count_q      <= '0;
      slow_count_q      <= '0;
      n_avg_q           <= '0;
      init_q            <= 1'b0;
      ready_q           <= 1'b0;
      armed_q           <= 1'b0;
      restart_pending_q <= 1'b0;
    end else begin
      fast_count_q      <= fast_count_d;
      slow_count_q      <= slow_count_d;
      n_avg_q           <= n_avg_d;
      init_q            <= init_d;
      ready_q           <= ready_d;
      armed_q           <= armed_d;
      restart_pending_q <= restart_pending_d;
    end
  end

  // Until the first restart has taken effect, the accumulator holds no valid
  // pass, so writes stay off. After that, writes follow the enable directly.
  assign wen        = armed_q & clken;

  assign fast_count = fast_count_q;
  assign slow_count = slow_count_q;
  assign n_avg      = n_avg_q;
  assign init       = init_q;
  assign ready      = ready_q;
  assign address    = {fast_count_q, {WORD_ADDR_SHIFT{1'b0}}};

endmodule : averager_counter

// File: tb/tb_averager_counter.sv
`timescale 1ns/1ps
module tb_averager_counter;

  logic       clk = 1'b0;
  logic       rst, restart, clken;
  logic [4:0] count_max;
  logic [4:0] fast_count;
  logic [9:0] slow_count, n_avg;
  logic       init, ready, wen;
  logic [6:0] address;

  logic       s_rst, s_restart, s_clken;
  logic [4:0] s_count_max, s_fast_count;
  logic [1:0] s_slow_count, s_n_avg;
  logic       s_init, s_ready, s_wen;
  logic [6:0] s_address;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  averager_counter #(.FAST_COUNT_WIDTH(5), .SLOW_COUNT_WIDTH(10)) u_dut (
    .clk(clk), .rst(rst), .restart(restart), .clken(clken),
    .count_max(count_max), .fast_count(fast_count), .slow_count(slow_count),
    .init(init), .ready(ready), .wen(wen), .n_avg(n_avg), .address(address)
  );

  averager_counter #(.FAST_COUNT_WIDTH(5), .SLOW_COUNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(s_rst), .restart(s_restart), .clken(s_clken),
    .count_max(s_count_max), .fast_count(s_fast_count), .slow_count(s_slow_count),
    .init(s_init), .ready(s_ready), .wen(s_wen), .n_avg(s_n_avg), .address(s_address)
  );

  typedef struct {
    logic       restart;
    logic       clken;
    logic [4:0] cm;
    int         fast;
    int         slow;
    int         init;
    int         ready;
    int         wen;
    int         navg;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic main_state(input string tag, input int f, input int s, input int in,
                            input int r, input int w, input int na);
    chk({tag, " fast_count"}, int'(fast_count), f);
    chk({tag, " slow_count"}, int'(slow_count), s);
    chk({tag, " init"}, int'(init), in);
    chk({tag, " ready"}, int'(ready), r);
    chk({tag, " wen"}, int'(wen), w);
    chk({tag, " n_avg"}, int'(n_avg), na);
    chk({tag, " address"}, int'(address), f * 4);
  endtask

  function automatic vec_t mk(input logic r, input logic c, input logic [4:0] cm,
                              input int f, input int s, input int in, input int rd,
                              input int w, input int na);
    vec_t v;
    v.restart = r; v.clken = c; v.cm = cm; v.fast = f; v.slow = s;
    v.init = in; v.ready = rd; v.wen = w; v.navg = na;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Short passes (count_max = 2), starting from reset.
    vecs[0]  = mk(0, 1, 2, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 2, 2, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 2, 0, 1, 0, 0, 0, 0);  // plain wrap
    vecs[3]  = mk(1, 1, 2, 1, 1, 0, 0, 0, 0);  // restart captured mid-pass
    vecs[4]  = mk(0, 0, 2, 1, 1, 0, 0, 0, 0);  // hold
    vecs[5]  = mk(0, 1, 2, 2, 1, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 2, 0, 0, 1, 1, 1, 2);  // pending restart takes effect
    vecs[7]  = mk(0, 1, 2, 1, 0, 1, 0, 1, 2);
    vecs[8]  = mk(0, 0, 2, 1, 0, 1, 0, 0, 2);  // hold, wen follows clken
    vecs[9]  = mk(0, 1, 2, 2, 0, 1, 0, 1, 2);
    vecs[10] = mk(1, 1, 2, 0, 0, 1, 1, 1, 1);  // restart on the wrap cycle
    vecs[11] = mk(0, 1, 2, 1, 0, 1, 0, 1, 1);
    vecs[12] = mk(0, 1, 2, 2, 0, 1, 0, 1, 1);
    vecs[13] = mk(0, 1, 2, 0, 1, 0, 0, 1, 1);  // pending was cleared
    vecs[14] = mk(0, 1, 0, 0, 2, 0, 0, 1, 1);  // count_max = 0: every cycle wraps
    vecs[15] = mk(0, 1, 0, 0, 3, 0, 0, 1, 1);
    vecs[16] = mk(1, 1, 0, 0, 0, 1, 1, 1, 4);
    vecs[17] = mk(0, 0, 0, 0, 0, 1, 0, 0, 4);

    rst = 1'b1; restart = 1'b0; clken = 1'b0; count_max = 5'd15;
    s_rst = 1'b1; s_restart = 1'b0; s_clken = 1'b0; s_count_max = 5'd1;
    tick(); tick();
    main_state("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;

    // Table of directed vectors.
    for (int i = 0; i < 18; i++) begin
      restart = vecs[i].restart; clken = vecs[i].clken; count_max = vecs[i].cm;
      tick();
      main_state($sformatf("vec%0d", i), vecs[i].fast, vecs[i].slow, vecs[i].init,
                 vecs[i].ready, vecs[i].wen, vecs[i].navg);
      $display("vec %0d: fast=%0d slow=%0d init=%0b ready=%0b wen=%0b n_avg=%0d",
               i, fast_count, slow_count, init, ready, wen, n_avg);
    end

    // Hold with the enable low for 10 cycles.
    restart = 1'b0; clken = 1'b0; count_max = 5'd15;
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    main_state("hold", 0, 0, 0, 0, 0, 0);
    $display("hold: fast=%0d slow=%0d", fast_count, slow_count);

    // Free run for 40 cycles, then a restart in mid-pass.
    clken = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("freerun fast", int'(fast_count), i % 16);
      chk("freerun slow", int'(slow_count), i / 16);
      chk("freerun wen", int'(wen), 0);
      chk("freerun init", int'(init), 0);
    end
    $display("freerun: fast=%0d slow=%0d", fast_count, slow_count);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrestart ready early", int'(ready), 0);
    end
    tick();
    main_state("midrestart wrap", 0, 0, 1, 1, 1, 3);
    $display("midrestart: n_avg=%0d ready=%0b", n_avg, ready);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("init pass init", int'(init), 1);
      chk("init pass ready", int'(ready), 0);
      chk("init pass wen", int'(wen), 1);
    end
    tick();
    main_state("second pass", 0, 1, 0, 0, 1, 3);

    // Asynchronous reset in mid-pass, with a restart pending.
    tick(); tick(); tick();
    restart = 1'b1; tick(); restart = 1'b0;
    #2 rst = 1'b1;
    #1 main_state("async rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    main_state("post-rst wrap", 0, 1, 0, 0, 0, 0);
    $display("post-rst: ready=%0b slow=%0d", ready, slow_count);

    // A restart captured while the enable is low.
    clken = 1'b0; restart = 1'b1; tick(); restart = 1'b0;
    chk("clken-low restart fast", int'(fast_count), 0);
    clken = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    main_state("clken-low restart wrap", 0, 0, 1, 1, 1, 2);

    // Lowering count_max while mid-pass.
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    count_max = 5'd15;
    for (int i = 0; i < 10; i++) tick();
    chk("cm change pre fast", int'(fast_count), 10);
    count_max = 5'd4;
    tick();
    chk("cm change fast", int'(fast_count), 0);
    chk("cm change slow", int'(slow_count), 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("period5 fast", int'(fast_count), i % 5);
    end
    chk("period5 slow", int'(slow_count), 2);
    $display("cm change: fast=%0d slow=%0d", fast_count, slow_count);

    // Saturation of a 2-bit slow counter.
    @(negedge clk); s_rst = 1'b0; s_clken = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    chk("sat fast", int'(s_fast_count), 1);
    chk("sat slow", int'(s_slow_count), 3);
    s_restart = 1'b1; tick(); s_restart = 1'b0;
    chk("sat n_avg", int'(s_n_avg), 3);
    chk("sat ready", int'(s_ready), 1);
    chk("sat slow cleared", int'(s_slow_count), 0);
    chk("sat init", int'(s_init), 1);
    $display("sat: n_avg=%0d slow=%0d", s_n_avg, s_slow_count);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_averager_counter
